// File: rtl/pwm_multi.sv
// pwm_multi -- multi-channel PWM generator with a shared period counter.
//
// All channels compare the same counter against their own active duty
// value. New duty values land in a shadow register and are copied to the
// active register only at a period boundary, so a period never shows a
// partially updated duty. The counting mode (edge- or center-aligned) is
// also latched at the boundary.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   duty         packed duty values, channel i at [i*WIDTH +: WIDTH]
//   duty_vld     capture all channels of duty into the shadow registers
//   center_mode  0 = edge-aligned, 1 = center-aligned (taken at boundary)
//   PWM_sig      registered PWM outputs, one per channel
//   period_start registered one-cycle pulse at the start of each period
module pwm_multi #(
   parameter int WIDTH    = 11,
   parameter int CHANNELS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] duty,
   input  logic                      duty_vld,
   input  logic                      center_mode,
   output logic [CHANNELS-1:0]       PWM_sig,
   output logic                      period_start
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0]    cnt;
   logic                dir;       // 0 = counting up, 1 = counting down
   logic                mode;      // 0 = edge-aligned, 1 = center-aligned
   logic                boundary;  // this edge moves cnt to 0 for a new period
   logic [CHANNELS-1:0] cmp;

   // In center mode cnt passes through M without ending the period; the
   // period ends when the down-count steps from 1 back to 0.
   always_comb begin
      boundary = 1'b0;
      if (mode) begin
         boundary = dir && (cnt == CNT_ONE);
      end else begin
         boundary = (cnt == CNT_MAX);
      end
   end

   // Shared period counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         dir          <= 1'b0;
         mode         <= 1'b0;
         period_start <= 1'b0;
      end else begin
         period_start <= boundary;
         if (boundary) begin
            // Every period restarts from 0 counting up, whichever mode follows.
            cnt  <= '0;
            dir  <= 1'b0;
            mode <= center_mode;
         end else if (!mode) begin
            cnt <= cnt + CNT_ONE;
         end else if (!dir) begin
            cnt <= cnt + CNT_ONE;
            // dir already reads "down" in the cycle where cnt sits at M.
            if (cnt == CNT_MAX - CNT_ONE) begin
               dir <= 1'b1;
            end
         end else begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   // Per-channel double-buffered duty and compare
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] duty_in;
      logic [WIDTH-1:0] shadow;
      logic [WIDTH-1:0] active;

      assign duty_in = duty[i*WIDTH +: WIDTH];
      assign cmp[i]  = (cnt < active);

      always_ff @(posedge clk) begin
         if (rst) begin
            shadow <= '0;
            active <= '0;
         end else begin
            if (duty_vld) begin
               shadow <= duty_in;
            end
            // A write landing on the boundary edge bypasses the shadow so it
            // takes effect in the period that is just starting.
            if (boundary) begin
               active <= duty_vld ? duty_in : shadow;
            end
         end
      end
   end

   // Output register: PWM_sig lags cnt by one cycle, aligned with period_start
   always_ff @(posedge clk) begin
      if (rst) begin
         PWM_sig <= '0;
      end else begin
         PWM_sig <= cmp;
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi -- directed bench for pwm_multi.
//
// Two instances share stimulus: an 11-bit one for the edge-mode, buffering
// and reset scenarios, and a 4-bit one for the center-mode scenarios. A
// monitor measures each complete period of the selected instance (length
// and high cycles per channel) and checks it against expectations queued by
// the stimulus sequence.
module tb_pwm_multi;

   typedef struct {
      int len;
      int h0;
      int h1;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        duty_vld;
   logic        center_mode;
   logic [21:0] duty11;
   logic [7:0]  duty4;
   logic [1:0]  pwm11;
   logic        ps11;
   logic [1:0]  pwm4;
   logic        ps4;
   logic        sel;          // 0 = monitor the 11-bit instance, 1 = 4-bit
   logic [1:0]  pwm_m;
   logic        ps_m;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;
   int   n_per    = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   pwm_multi #(.WIDTH(11), .CHANNELS(2)) u_w11 (
      .clk          (clk),
      .rst          (rst),
      .duty         (duty11),
      .duty_vld     (duty_vld),
      .center_mode  (center_mode),
      .PWM_sig      (pwm11),
      .period_start (ps11)
   );

   pwm_multi #(.WIDTH(4), .CHANNELS(2)) u_w4 (
      .clk          (clk),
      .rst          (rst),
      .duty         (duty4),
      .duty_vld     (duty_vld),
      .center_mode  (center_mode),
      .PWM_sig      (pwm4),
      .period_start (ps4)
   );

   assign pwm_m = sel ? pwm4 : pwm11;
   assign ps_m  = sel ? ps4  : ps11;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Period monitor. A window opens after a period_start cycle and closes at
   // the next period_start cycle (inclusive), which is exactly the span in
   // which PWM_sig shows that period's compares.
   int   len_m = 0;
   int   hi0_m = 0;
   int   hi1_m = 0;
   bit   win_valid = 1'b0;
   exp_t e;

   always @(negedge clk) begin
      if (rst) begin
         win_valid = 1'b0;
         len_m = 0;
         hi0_m = 0;
         hi1_m = 0;
      end else begin
         len_m++;
         hi0_m += int'(pwm_m[0]);
         hi1_m += int'(pwm_m[1]);
         if (ps_m) begin
            if (win_valid && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_per++;
               check($sformatf("period%0d_len", n_per), len_m, e.len);
               check($sformatf("period%0d_hi0", n_per), hi0_m, e.h0);
               check($sformatf("period%0d_hi1", n_per), hi1_m, e.h1);
            end
            win_valid = 1'b1;
            len_m = 0;
            hi0_m = 0;
            hi1_m = 0;
         end
      end
   end

   task automatic push_exp(input int len, input int h0, input int h1);
      exp_t x;
      x.len = len;
      x.h0  = h0;
      x.h1  = h1;
      exp_q.push_back(x);
   endtask

   // Drive one duty write; it is captured at the next rising edge.
   task automatic write_duty(input int c0, input int c1);
      duty11   = {11'(c1), 11'(c0)};
      duty4    = {4'(c1), 4'(c0)};
      duty_vld = 1'b1;
      @(posedge clk); #1;
      duty_vld = 1'b0;
   endtask

   // Returns at the falling edge of the next period_start cycle (cnt == 0).
   task automatic wait_ps(input string tag, input int limit);
      int n = 0;
      @(negedge clk);
      while (!ps_m && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ps_seen"}, int'(ps_m), 1);
   endtask

   // Waits until the monitor has consumed every queued expectation.
   task automatic wait_done(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 12000) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst         = 1'b1;
      duty_vld    = 1'b0;
      center_mode = 1'b0;
      duty11      = '0;
      duty4       = '0;
      sel         = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_pwm11", int'(pwm11), 0);
      check("rst_ps11",  int'(ps11),  0);
      check("rst_pwm4",  int'(pwm4),  0);
      check("rst_ps4",   int'(ps4),   0);
      rst = 1'b0;

      // First period after reset is edge mode, 16 clocks, no early pulse
      n = 0;
      while (!ps4 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_to_first_ps4", n, 16);

      // Edge mode, ch0 = 1, ch1 = 0x400, two periods
      write_duty(12'h001, 12'h400);
      wait_ps("t1", 2100);
      @(posedge clk); #1;
      push_exp(2048, 1, 1024);
      push_exp(2048, 1, 1024);
      wait_done("t1");

      // Edge mode, ch0 = M, ch1 = 0
      write_duty(12'h7FF, 12'h000);
      wait_ps("t2", 2100);
      @(posedge clk); #1;
      push_exp(2048, 2047, 0);
      wait_done("t2");

      // Double buffering: mid-period write affects only the next period
      write_duty(12'h100, 12'h100);
      wait_ps("t3a", 2100);
      @(posedge clk); #1;
      push_exp(2048, 256, 256);
      push_exp(2048, 1536, 1536);
      repeat (12'h1FF) begin
         @(posedge clk); #1;
      end
      write_duty(12'h600, 12'h600);
      wait_done("t3a");

      // Two writes in one period: last one wins
      write_duty(12'h300, 12'h300);
      repeat (100) begin
         @(posedge clk); #1;
      end
      write_duty(12'h080, 12'h080);
      wait_ps("t3b", 2100);
      @(posedge clk); #1;
      push_exp(2048, 128, 128);
      wait_done("t3b");

      // Write in the cnt == M cycle applies to the very next period
      wait_ps("t4", 2100);
      @(posedge clk); #1;
      push_exp(2048, 128, 128);
      push_exp(2048, 80, 80);
      repeat (2046) begin
         @(posedge clk); #1;
      end
      write_duty(12'h050, 12'h050);
      wait_done("t4");

      // Reset mid-period with 0x400 active
      write_duty(12'h400, 12'h400);
      wait_ps("t6", 2100);
      repeat (100) begin
         @(posedge clk); #1;
      end
      check("t6_pwm_before_rst", int'(pwm11), 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t6_pwm_after_rst", int'(pwm11), 0);
      check("t6_ps_after_rst",  int'(ps11),  0);
      n = 0;
      while (!ps11 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check("t6_rst_to_ps", n, 2048);
      push_exp(2048, 0, 0);
      wait_done("t6");

      // Center mode on the 4-bit instance
      rst = 1'b1;
      @(posedge clk); #1;
      sel = 1'b1;
      rst = 1'b0;
      write_duty(5, 0);
      wait_ps("t5a", 40);
      @(posedge clk); #1;
      push_exp(16, 5, 0);      // mode raised mid-period: still edge here
      push_exp(30, 9, 0);      // center: 2*5-1 high, duty 0 stays low
      repeat (4) begin
         @(posedge clk); #1;
      end
      center_mode = 1'b1;
      wait_done("t5a");

      write_duty(15, 1);
      wait_ps("t5b", 80);
      @(posedge clk); #1;
      push_exp(30, 29, 1);     // center: 2*15-1 and 2*1-1
      push_exp(16, 15, 1);     // back to edge at the next boundary
      repeat (3) begin
         @(posedge clk); #1;
      end
      center_mode = 1'b0;
      wait_done("t5b");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
